// File: rtl/sdram_responder.sv
// SDRAM command-interface responder for the DLX controller.
// Decodes CS/RAS/CAS/WE commands, tracks open rows per bank, holds the mode
// register (burst length, CAS latency) and serves read/write bursts from an
// internal word array indexed {bank, low row bits, low column bits}.
module sdram_responder #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 12,
    parameter int BA_WIDTH       = 2,
    parameter int DQM_WIDTH      = 4,
    parameter int ROW_STORE_BITS = 2,
    parameter int COL_STORE_BITS = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dram_cke,
    input  logic                  dram_cs_n,
    input  logic                  dram_ras_n,
    input  logic                  dram_cas_n,
    input  logic                  dram_we_n,
    input  logic [BA_WIDTH-1:0]   dram_ba,
    input  logic [ADDR_WIDTH-1:0] dram_addr,
    input  logic [DQM_WIDTH-1:0]  dram_dqm,
    input  logic [DATA_WIDTH-1:0] dram_dq_in,
    output logic [DATA_WIDTH-1:0] dram_dq_out,
    output logic                  dram_dq_oe,
    output logic                  cmd_err,
    output logic [15:0]           refresh_cnt
);
    localparam int NUM_BANKS = 1 << BA_WIDTH;
    localparam int MEM_AW    = BA_WIDTH + ROW_STORE_BITS + COL_STORE_BITS;
    localparam int MEM_DEPTH = 1 << MEM_AW;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RD_BURST = 2'd1,
        ST_WR_BURST = 2'd2
    } burst_state_t;

    // Storage and control state
    logic [DATA_WIDTH-1:0]     mem_r [MEM_DEPTH];
    logic [NUM_BANKS-1:0]      bank_open_r;
    logic [ROW_STORE_BITS-1:0] open_row_r [NUM_BANKS];
    logic [1:0]                bl_code_r;      // burst length = 1 << bl_code_r
    logic                      cl3_r;          // 1: CAS latency 3, 0: CAS latency 2
    burst_state_t              state_r;
    logic [2:0]                burst_cnt_r;    // index of the next burst word
    logic [BA_WIDTH-1:0]       burst_ba_r;
    logic [COL_STORE_BITS-1:0] burst_start_r;
    logic                      burst_ap_r;
    logic                      pipe1_v_r;
    logic                      pipe2_v_r;
    logic [DATA_WIDTH-1:0]     pipe1_d_r;
    logic [DATA_WIDTH-1:0]     pipe2_d_r;

    // Decoded command strobes and derived combinational signals
    logic is_act_s, is_rd_s, is_wr_s, is_pre_s, is_ref_s, is_lmr_s, is_bt_s;
    logic all_idle_s, cmd_bank_open_s;
    logic lmr_ok_s, act_ok_s, rw_ok_s, ref_ok_s, err_s;
    logic [COL_STORE_BITS-1:0] bl_mask_s;
    logic [2:0]                bl_last_s;
    logic burst_busy_s, intr_s, cont_s;
    logic [COL_STORE_BITS-1:0] burst_col_s;
    logic [COL_STORE_BITS-1:0] cmd_col_s;
    logic [MEM_AW-1:0]         acc_addr_s;
    logic                      rd_v_s;
    logic                      wr_en_s;
    logic [DATA_WIDTH-1:0]     rd_d_s;
    logic                      src_v_s;
    logic [DATA_WIDTH-1:0]     src_d_s;
    logic                      unused_addr_s;

    // Not every address bit carries meaning for every command
    assign unused_addr_s = ^dram_addr;

    // Decode the command word; nothing is decoded while the clock enable is low
    always_comb begin
        is_act_s = 1'b0;
        is_rd_s  = 1'b0;
        is_wr_s  = 1'b0;
        is_pre_s = 1'b0;
        is_ref_s = 1'b0;
        is_lmr_s = 1'b0;
        is_bt_s  = 1'b0;
        if (dram_cke) begin
            case ({dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n})
                4'b0011: is_act_s = 1'b1;
                4'b0101: is_rd_s  = 1'b1;
                4'b0100: is_wr_s  = 1'b1;
                4'b0010: is_pre_s = 1'b1;
                4'b0001: is_ref_s = 1'b1;
                4'b0000: is_lmr_s = 1'b1;
                4'b0110: is_bt_s  = 1'b1;
                default: is_act_s = 1'b0;   // NOP or deselect
            endcase
        end else begin
            is_act_s = 1'b0;
        end
    end

    // Command legality, burst interruption and the current burst column
    always_comb begin
        all_idle_s      = (bank_open_r == {NUM_BANKS{1'b0}});
        cmd_bank_open_s = bank_open_r[dram_ba];
        lmr_ok_s        = is_lmr_s & all_idle_s;
        act_ok_s        = is_act_s & ~cmd_bank_open_s;
        rw_ok_s         = (is_rd_s | is_wr_s) & cmd_bank_open_s;
        ref_ok_s        = is_ref_s & all_idle_s;
        err_s           = (is_lmr_s & ~all_idle_s)
                        | (is_act_s & cmd_bank_open_s)
                        | ((is_rd_s | is_wr_s) & ~cmd_bank_open_s)
                        | (is_ref_s & ~all_idle_s);
        case (bl_code_r)
            2'd0:    bl_mask_s = COL_STORE_BITS'(0);
            2'd1:    bl_mask_s = COL_STORE_BITS'(1);
            2'd2:    bl_mask_s = COL_STORE_BITS'(3);
            2'd3:    bl_mask_s = COL_STORE_BITS'(7);
            default: bl_mask_s = COL_STORE_BITS'(0);
        endcase
        bl_last_s    = bl_mask_s[2:0];
        burst_busy_s = (state_r != ST_IDLE);
        // Any READ/WRITE, a terminate, or a precharge hitting the burst bank stops the burst
        intr_s       = burst_busy_s & (is_rd_s | is_wr_s | is_bt_s |
                       (is_pre_s & (dram_addr[10] | (dram_ba == burst_ba_r))));
        cont_s       = dram_cke & burst_busy_s & ~intr_s;
        // Sequential wrap inside the BL-aligned block
        burst_col_s  = (burst_start_r & ~bl_mask_s) |
                       ((burst_start_r + COL_STORE_BITS'(burst_cnt_r)) & bl_mask_s);
        cmd_col_s    = dram_addr[COL_STORE_BITS-1:0];
    end

    // Pick the array word touched this cycle: a new command's first word or the next burst word
    always_comb begin
        acc_addr_s = {MEM_AW{1'b0}};
        rd_v_s     = 1'b0;
        wr_en_s    = 1'b0;
        if (rw_ok_s) begin
            acc_addr_s = {dram_ba, open_row_r[dram_ba], cmd_col_s};
            rd_v_s     = is_rd_s;
            wr_en_s    = is_wr_s & ~rst;
        end else if (cont_s) begin
            acc_addr_s = {burst_ba_r, open_row_r[burst_ba_r], burst_col_s};
            rd_v_s     = (state_r == ST_RD_BURST);
            wr_en_s    = (state_r == ST_WR_BURST) & ~rst;
        end else begin
            rd_v_s     = 1'b0;
        end
    end

    assign rd_d_s  = mem_r[acc_addr_s];
    assign src_v_s = cl3_r ? pipe2_v_r : pipe1_v_r;
    assign src_d_s = cl3_r ? pipe2_d_r : pipe1_d_r;

    // Byte-masked array write; contents survive reset
    always_ff @(posedge clk) begin
        for (int b = 0; b < DQM_WIDTH; b++) begin
            if (wr_en_s && !dram_dqm[b]) begin
                mem_r[acc_addr_s][8*b +: 8] <= dram_dq_in[8*b +: 8];
            end
        end
    end

    // Bank/mode bookkeeping, burst state machine, read pipeline and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_open_r   <= {NUM_BANKS{1'b0}};
            for (int i = 0; i < NUM_BANKS; i++) begin
                open_row_r[i] <= {ROW_STORE_BITS{1'b0}};
            end
            bl_code_r     <= 2'd0;
            cl3_r         <= 1'b0;
            state_r       <= ST_IDLE;
            burst_cnt_r   <= 3'd0;
            burst_ba_r    <= {BA_WIDTH{1'b0}};
            burst_start_r <= {COL_STORE_BITS{1'b0}};
            burst_ap_r    <= 1'b0;
            pipe1_v_r     <= 1'b0;
            pipe2_v_r     <= 1'b0;
            pipe1_d_r     <= {DATA_WIDTH{1'b0}};
            pipe2_d_r     <= {DATA_WIDTH{1'b0}};
            dram_dq_out   <= {DATA_WIDTH{1'b0}};
            dram_dq_oe    <= 1'b0;
            cmd_err       <= 1'b0;
            refresh_cnt   <= 16'd0;
        end else if (dram_cke) begin
            cmd_err <= err_s;
            if (ref_ok_s && (refresh_cnt != 16'hFFFF)) begin
                refresh_cnt <= refresh_cnt + 16'd1;
            end
            if (lmr_ok_s) begin
                bl_code_r <= dram_addr[2] ? 2'd0 : dram_addr[1:0];
                cl3_r     <= (dram_addr[6:4] == 3'd3);
            end

            // Advance or stop an ongoing burst
            case (state_r)
                ST_IDLE: state_r <= ST_IDLE;
                ST_RD_BURST, ST_WR_BURST: begin
                    if (intr_s) begin
                        state_r <= ST_IDLE;
                    end else if (burst_cnt_r == bl_last_s) begin
                        state_r <= ST_IDLE;
                        if (burst_ap_r) begin
                            bank_open_r[burst_ba_r] <= 1'b0;
                        end
                    end else begin
                        burst_cnt_r <= burst_cnt_r + 3'd1;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase

            if (act_ok_s) begin
                bank_open_r[dram_ba] <= 1'b1;
                open_row_r[dram_ba]  <= dram_addr[ROW_STORE_BITS-1:0];
            end
            if (is_pre_s) begin
                if (dram_addr[10]) begin
                    bank_open_r <= {NUM_BANKS{1'b0}};
                end else begin
                    bank_open_r[dram_ba] <= 1'b0;
                end
            end

            // A legal READ/WRITE serves word 0 now and starts a burst for the rest
            if (rw_ok_s) begin
                if (bl_last_s == 3'd0) begin
                    state_r <= ST_IDLE;
                    if (dram_addr[10]) begin
                        bank_open_r[dram_ba] <= 1'b0;
                    end
                end else begin
                    state_r       <= is_rd_s ? ST_RD_BURST : ST_WR_BURST;
                    burst_cnt_r   <= 3'd1;
                    burst_ba_r    <= dram_ba;
                    burst_start_r <= cmd_col_s;
                    burst_ap_r    <= dram_addr[10];
                end
            end

            // CAS-latency pipeline: output taps stage 1 for CL2, stage 2 for CL3
            pipe1_v_r   <= rd_v_s;
            pipe1_d_r   <= rd_d_s;
            pipe2_v_r   <= pipe1_v_r;
            pipe2_d_r   <= pipe1_d_r;
            dram_dq_oe  <= src_v_s;
            dram_dq_out <= src_v_s ? src_d_s : {DATA_WIDTH{1'b0}};
        end else begin
            // Clock enable low: everything holds
            state_r <= state_r;
        end
    end

endmodule

// File: tb/tb_sdram_responder.sv
// Self-checking bench for sdram_responder: directed command sequences, a
// schedule-based reference model compared every cycle, plus literal checks.
module tb_sdram_responder;
    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_REF = 4'b0001;
    localparam logic [3:0] C_LMR = 4'b0000;

    logic        clk = 1'b0;
    logic        rst, cke, cs_n, ras_n, cas_n, we_n;
    logic [1:0]  ba;
    logic [11:0] addr;
    logic [3:0]  dqm;
    logic [31:0] dq_in;
    logic [31:0] dq_out;
    logic        dq_oe, cmd_err;
    logic [15:0] refresh_cnt;

    sdram_responder dut (
        .clk(clk), .rst(rst), .dram_cke(cke), .dram_cs_n(cs_n), .dram_ras_n(ras_n),
        .dram_cas_n(cas_n), .dram_we_n(we_n), .dram_ba(ba), .dram_addr(addr),
        .dram_dqm(dqm), .dram_dq_in(dq_in), .dram_dq_out(dq_out), .dram_dq_oe(dq_oe),
        .cmd_err(cmd_err), .refresh_cnt(refresh_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    // Reference model state
    bit          m_open [4];
    logic [11:0] m_row [4];
    int          m_bl, m_cl;
    logic [31:0] m_mem [1024];
    bit          sched_v [4096];
    logic [31:0] sched_d [4096];
    int          act = 0;
    bit          b_act, b_wr, b_ap;
    int          b_a0, b_end, b_bl;
    logic [1:0]  b_ba;
    logic [11:0] b_row;
    logic [5:0]  b_start;
    logic [15:0] m_ref;
    logic        n_oe, n_err;
    logic [31:0] n_dq;
    logic        exp_oe, exp_err;
    logic [31:0] exp_dq;
    logic [15:0] exp_ref;
    logic        obs_oe [1024];
    logic        obs_err [1024];
    logic [31:0] obs_dq [1024];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
        n_cmp++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h (cycle %0d)", nm, got, req, cyc);
        end
    endtask

    function automatic logic [5:0] wcol(input logic [5:0] s, input int i, input int bl);
        logic [5:0] m;
        m = 6'(bl - 1);
        return (s & ~m) | (6'(int'(s) + i) & m);
    endfunction

    function automatic int midx(input logic [1:0] b, input logic [11:0] r, input logic [5:0] c);
        return int'({b, r[1:0], c});
    endfunction

    task automatic mwrite(input int idx, input logic [31:0] d, input logic [3:0] mask);
        for (int j = 0; j < 4; j++) begin
            if (!mask[j]) m_mem[idx][8*j +: 8] = d[8*j +: 8];
        end
    endtask

    // One clock edge of the model, using the inputs presented for this cycle
    task automatic model_step();
        logic [3:0] c;
        bit any_open, err;
        bit pre_open [4];
        if (rst) begin
            for (int i = 0; i < 4; i++) m_open[i] = 1'b0;
            for (int i = 0; i < 4096; i++) sched_v[i] = 1'b0;
            m_bl = 1; m_cl = 2; b_act = 1'b0; m_ref = 16'd0;
            n_oe = 1'b0; n_err = 1'b0;
            return;
        end
        if (!cke) return;
        act++;
        c = cs_n ? C_NOP : {1'b0, ras_n, cas_n, we_n};
        pre_open = m_open;
        any_open = pre_open[0] | pre_open[1] | pre_open[2] | pre_open[3];
        err = 1'b0;
        if (b_act && (c == C_RD || c == C_WR || c == 4'b0110 ||
                      (c == C_PRE && (addr[10] || ba == b_ba)))) begin
            if (!b_wr) for (int e = act; e <= b_end; e++) sched_v[e + m_cl - 1] = 1'b0;
            b_act = 1'b0;
        end
        if (b_act && b_wr) mwrite(midx(b_ba, b_row, wcol(b_start, act - b_a0, b_bl)), dq_in, dqm);
        if (b_act && b_end == act) begin
            if (b_ap) m_open[b_ba] = 1'b0;
            b_act = 1'b0;
        end
        case (c)
            C_LMR: if (any_open) err = 1'b1;
                   else begin
                       case (addr[2:0])
                           3'b000: m_bl = 1;
                           3'b001: m_bl = 2;
                           3'b010: m_bl = 4;
                           3'b011: m_bl = 8;
                           default: m_bl = 1;
                       endcase
                       m_cl = (addr[6:4] == 3'd3) ? 3 : 2;
                   end
            C_ACT: if (pre_open[ba]) err = 1'b1;
                   else begin m_open[ba] = 1'b1; m_row[ba] = addr; end
            C_PRE: if (addr[10]) for (int i = 0; i < 4; i++) m_open[i] = 1'b0;
                   else m_open[ba] = 1'b0;
            C_REF: if (any_open) err = 1'b1;
                   else if (m_ref != 16'hFFFF) m_ref = m_ref + 16'd1;
            C_RD, C_WR: if (!pre_open[ba]) err = 1'b1;
                   else begin
                       b_a0 = act; b_end = act + m_bl - 1; b_ba = ba; b_row = m_row[ba];
                       b_start = addr[5:0]; b_bl = m_bl; b_ap = addr[10]; b_wr = (c == C_WR);
                       b_act = 1'b1;
                       if (c == C_RD) begin
                           for (int i = 0; i < m_bl; i++) begin
                               sched_v[act + i + m_cl - 1] = 1'b1;
                               sched_d[act + i + m_cl - 1] = m_mem[midx(ba, b_row, wcol(b_start, i, m_bl))];
                           end
                       end else begin
                           mwrite(midx(ba, b_row, b_start), dq_in, dqm);
                       end
                       if (b_end == act) begin
                           if (b_ap) m_open[ba] = 1'b0;
                           b_act = 1'b0;
                       end
                   end
            default: err = 1'b0;
        endcase
        n_oe = sched_v[act]; n_dq = sched_d[act]; n_err = err;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        exp_oe = n_oe; exp_dq = n_dq; exp_err = n_err; exp_ref = m_ref;
        cyc++;
        #1;
    endtask

    task automatic issue(input logic [3:0] c, input logic [1:0] b, input logic [11:0] a);
        {cs_n, ras_n, cas_n, we_n} = c;
        ba = b; addr = a;
        tick();
        {cs_n, ras_n, cas_n, we_n} = C_NOP;
    endtask

    task automatic nop(input int n);
        {cs_n, ras_n, cas_n, we_n} = C_NOP;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr_burst(input logic [1:0] b, input logic [11:0] a, input logic [31:0] base, input int n);
        dqm = 4'b0000;
        dq_in = base;
        issue(C_WR, b, a);
        for (int i = 1; i < n; i++) begin
            dq_in = base + 32'(i);
            tick();
        end
    endtask

    // Every-cycle comparison against the model, plus a record for literal checks
    initial forever begin
        @(negedge clk);
        if (cyc < 1024) begin
            obs_oe[cyc] = dq_oe; obs_dq[cyc] = dq_out; obs_err[cyc] = cmd_err;
        end
        if (chk_en) begin
            chk("oe", 32'(dq_oe), 32'(exp_oe));
            if (exp_oe) chk("dq", dq_out, exp_dq);
            chk("cmd_err", 32'(cmd_err), 32'(exp_err));
            chk("refresh_cnt", 32'(refresh_cnt), 32'(exp_ref));
        end
    end

    initial begin
        int k;
        for (int i = 0; i < 1024; i++) m_mem[i] = 32'd0;
        rst = 1'b1; cke = 1'b1; {cs_n, ras_n, cas_n, we_n} = C_NOP;
        ba = 2'd0; addr = 12'd0; dqm = 4'd0; dq_in = 32'd0;
        tick(); chk_en = 1'b1; tick();
        rst = 1'b0;
        chk("rst_oe", 32'(dq_oe), 32'd0);
        chk("rst_err", 32'(cmd_err), 32'd0);
        chk("rst_refresh", 32'(refresh_cnt), 32'd0);

        // Legal refresh with all banks idle
        issue(C_REF, 2'd0, 12'd0);
        chk("refresh_one", 32'(refresh_cnt), 32'd1);

        // BL4 CL2 write then read with wrap
        issue(C_LMR, 2'd0, 12'h022);
        issue(C_ACT, 2'd1, 12'd3);
        wr_burst(2'd1, 12'h005, 32'hA0, 4);
        nop(2);
        k = cyc; issue(C_RD, 2'd1, 12'h005); nop(6);
        chk("bl4_pre_oe", 32'(obs_oe[k+1]), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("bl4_oe", 32'(obs_oe[k+2+i]), 32'd1);
            chk("bl4_dq", obs_dq[k+2+i], 32'hA0 + 32'(i));
        end
        chk("bl4_post_oe", 32'(obs_oe[k+6]), 32'd0);
        k = cyc; issue(C_RD, 2'd1, 12'h004); nop(6);
        chk("bl4_col4_dq", obs_dq[k+2], 32'hA3);
        chk("bl4_col5_dq", obs_dq[k+3], 32'hA0);

        // Byte mask with BL1
        issue(C_PRE, 2'd0, 12'h400);
        issue(C_LMR, 2'd0, 12'h020);
        issue(C_ACT, 2'd2, 12'd1);
        dqm = 4'b0000; dq_in = 32'h11223344; issue(C_WR, 2'd2, 12'h010);
        dqm = 4'b0101; dq_in = 32'hFFFFFFFF; issue(C_WR, 2'd2, 12'h010);
        dqm = 4'b0000; nop(1);
        k = cyc; issue(C_RD, 2'd2, 12'h010); nop(3);
        chk("mask_oe", 32'(obs_oe[k+2]), 32'd1);
        chk("mask_dq", obs_dq[k+2], 32'hFF22FF44);

        // Protocol errors
        k = cyc; issue(C_RD, 2'd0, 12'h000); nop(3);
        chk("rd_closed_err", 32'(obs_err[k+1]), 32'd1);
        chk("rd_closed_oe", 32'(obs_oe[k+2]), 32'd0);
        k = cyc; issue(C_ACT, 2'd2, 12'd1); nop(1);
        chk("act_open_err", 32'(obs_err[k+1]), 32'd1);
        k = cyc; issue(C_REF, 2'd0, 12'd0); nop(1);
        chk("ref_open_err", 32'(obs_err[k+1]), 32'd1);
        chk("ref_open_cnt", 32'(refresh_cnt), 32'd1);

        // BL8 CL3 read interrupted by an auto-precharge read two cycles later
        issue(C_PRE, 2'd0, 12'h400);
        issue(C_LMR, 2'd0, 12'h033);
        issue(C_ACT, 2'd1, 12'd3);
        wr_burst(2'd1, 12'h000, 32'hB0, 8);
        nop(2);
        k = cyc; issue(C_RD, 2'd1, 12'h000); nop(1);
        issue(C_RD, 2'd1, 12'h402); nop(14);
        chk("cl3_pre_oe", 32'(obs_oe[k+2]), 32'd0);
        chk("cl3_first0", obs_dq[k+3], 32'hB0);
        chk("cl3_first1", obs_dq[k+4], 32'hB1);
        for (int i = 0; i < 8; i++) begin
            chk("cl3_second_oe", 32'(obs_oe[k+5+i]), 32'd1);
            chk("cl3_second_dq", obs_dq[k+5+i], 32'hB0 + 32'((i + 2) % 8));
        end
        chk("cl3_post_oe", 32'(obs_oe[k+13]), 32'd0);
        k = cyc; issue(C_RD, 2'd1, 12'h000); nop(1);
        chk("autopre_closed_err", 32'(obs_err[k+1]), 32'd1);

        // Reset in the middle of a BL8 read
        issue(C_ACT, 2'd1, 12'd3);
        k = cyc; issue(C_RD, 2'd1, 12'h000); nop(3);
        rst = 1'b1; tick(); rst = 1'b0;
        nop(2);
        chk("rstmid_oe_before", 32'(obs_oe[k+4]), 32'd1);
        chk("rstmid_oe_after", 32'(obs_oe[k+5]), 32'd0);
        chk("rstmid_refresh", 32'(refresh_cnt), 32'd0);
        issue(C_ACT, 2'd1, 12'd3);
        k = cyc; issue(C_RD, 2'd1, 12'h005); nop(4);
        chk("rstmid_bl1_pre", 32'(obs_oe[k+1]), 32'd0);
        chk("rstmid_bl1_oe", 32'(obs_oe[k+2]), 32'd1);
        chk("rstmid_bl1_dq", obs_dq[k+2], 32'hB5);
        chk("rstmid_bl1_post", 32'(obs_oe[k+3]), 32'd0);

        // CKE low for three cycles during a BL4 read
        issue(C_PRE, 2'd0, 12'h400);
        issue(C_LMR, 2'd0, 12'h022);
        issue(C_ACT, 2'd1, 12'd3);
        k = cyc; issue(C_RD, 2'd1, 12'h000); nop(2);
        cke = 1'b0; nop(3); cke = 1'b1; nop(5);
        chk("cke_d0", obs_dq[k+2], 32'hB0);
        chk("cke_d1", obs_dq[k+3], 32'hB1);
        for (int i = 4; i <= 6; i++) begin
            chk("cke_hold_oe", 32'(obs_oe[k+i]), 32'd1);
            chk("cke_hold_dq", obs_dq[k+i], 32'hB1);
        end
        chk("cke_d2", obs_dq[k+7], 32'hB2);
        chk("cke_d3", obs_dq[k+8], 32'hB3);
        chk("cke_post_oe", 32'(obs_oe[k+9]), 32'd0);

        nop(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
